// File: rtl/sram_wr_pkg.sv
// Shared types and default timing for the SRAM write driver.
// Contents:
//   wr_state_t     - sequencer state encoding (IDLE, PRECH, DRIVE, RECOVER)
//   DEF_COLS       - default column count / data width
//   DEF_PRECH_CYC  - default precharge length before drive
//   DEF_DRV_CYC    - default wordline/drive length
package sram_wr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRECH   = 2'd1,
        DRIVE   = 2'd2,
        RECOVER = 2'd3
    } wr_state_t;

    localparam int DEF_COLS      = 16;
    localparam int DEF_PRECH_CYC = 2;
    localparam int DEF_DRV_CYC   = 3;

endpackage

// File: rtl/sram_write_driver_if.sv
// Write-request channel between the SRAM controller and the write driver.
// Signals:
//   req_valid - request valid (controller -> driver)
//   req_ready - driver can accept a request (driver -> controller)
//   wr_data   - COLS-wide write word
//   wr_mask   - per-column write enable, 1 = write that column
// Modports: master = controller side, slave = write driver side.
interface sram_write_driver_if #(
    parameter int COLS = 16
);
    logic            req_valid;
    logic            req_ready;
    logic [COLS-1:0] wr_data;
    logic [COLS-1:0] wr_mask;

    modport master (output req_valid, output wr_data, output wr_mask, input req_ready);
    modport slave  (input req_valid, input wr_data, input wr_mask, output req_ready);
endinterface

// File: rtl/sram_wr_col_drv.sv
// Single-column bitline driver decode (combinational).
// Ports:
//   state    - sequencer state the column should reflect
//   mask_bit - write enable for this column
//   data_bit - value to write into this column
//   drv_en   - column driver enable
//   bl, blb  - bitline / complementary bitline drive values
// An undriven column parks both lines high so bl and blb are never both 0.
module sram_wr_col_drv
    import sram_wr_pkg::*;
(
    input  wr_state_t state,
    input  logic      mask_bit,
    input  logic      data_bit,
    output logic      drv_en,
    output logic      bl,
    output logic      blb
);
    assign drv_en = (state == DRIVE) && mask_bit;
    assign bl     = drv_en ? data_bit  : 1'b1;
    assign blb    = drv_en ? ~data_bit : 1'b1;
endmodule

// File: rtl/sram_write_driver.sv
// SRAM write-path sequencer: accepts a masked write word over a valid/ready
// handshake, then precharges, drives wordline + complementary bitlines on
// the enabled columns, and recovers with a re-precharge.
// Ports:
//   clk, rst      - clock; asynchronous active-high reset
//   req           - write request channel (slave modport)
//   pre_en        - bitline precharge enable
//   wl_en         - wordline enable
//   col_drv_en    - per-column driver enable
//   bl_wr, blb_wr - per-column BL / BLB drive values
//   done          - one-cycle pulse when the write sequence completes
//   preout        - sense-amp readback (SRAM_WR_VERIFY_EN only)
//   verify_err    - readback mismatch pulse, aligned with done
//                   (SRAM_WR_VERIFY_EN only)
// Optional feature macro: SRAM_WR_VERIFY_EN.
module sram_write_driver
    import sram_wr_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int PRECH_CYC = DEF_PRECH_CYC,
    parameter int DRV_CYC   = DEF_DRV_CYC
) (
    input  logic                     clk,
    input  logic                     rst,
    sram_write_driver_if.slave       req,
    output logic                     pre_en,
    output logic                     wl_en,
    output logic [COLS-1:0]          col_drv_en,
    output logic [COLS-1:0]          bl_wr,
    output logic [COLS-1:0]          blb_wr,
`ifdef SRAM_WR_VERIFY_EN
    input  logic [COLS-1:0]          preout,
    output logic                     verify_err,
`endif
    output logic                     done
);
    localparam int MAX_CYC = (PRECH_CYC > DRV_CYC) ? PRECH_CYC : DRV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] PRECH_LAST = CNT_W'(PRECH_CYC - 1);
    localparam logic [CNT_W-1:0] DRV_LAST   = CNT_W'(DRV_CYC - 1);

    wr_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [COLS-1:0]  data_q, data_d;
    logic [COLS-1:0]  mask_q, mask_d;
    logic [COLS-1:0]  drv_d, bl_d, blb_d;

    assign req.req_ready = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        data_d  = data_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req.req_valid) begin
                    data_d  = req.wr_data;
                    mask_d  = req.wr_mask;
                    // An all-zero mask skips the array entirely.
                    state_d = (|req.wr_mask) ? PRECH : RECOVER;
                end
            end
            PRECH:   if (cnt_q == PRECH_LAST) state_d = DRIVE;
            DRIVE:   if (cnt_q == DRV_LAST)   state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Columns decode from next-state values so the registered outputs line
    // up with the state they describe.
    for (genvar i = 0; i < COLS; i++) begin : g_col
        sram_wr_col_drv u_col (
            .state    (state_d),
            .mask_bit (mask_d[i]),
            .data_bit (data_d[i]),
            .drv_en   (drv_d[i]),
            .bl       (bl_d[i]),
            .blb      (blb_d[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            pre_en     <= 1'b1;
            wl_en      <= 1'b0;
            col_drv_en <= '0;
            bl_wr      <= '1;
            blb_wr     <= '1;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            pre_en     <= (state_d != DRIVE);
            wl_en      <= (state_d == DRIVE);
            col_drv_en <= drv_d;
            bl_wr      <= bl_d;
            blb_wr     <= blb_d;
            done       <= (state_d == RECOVER);
        end
    end

`ifdef SRAM_WR_VERIFY_EN
    // Compare on the last drive cycle; the flag lands in RECOVER with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            verify_err <= 1'b0;
        end else begin
            verify_err <= (state_q == DRIVE) && (cnt_q == DRV_LAST) &&
                          (|((preout ^ data_q) & mask_q));
        end
    end
`endif

endmodule

// File: tb/tb_sram_write_driver.sv
module tb_sram_write_driver;
    localparam int COLS = 16;

    logic clk;
    logic rst;
    logic pre_en, wl_en, done;
    logic [COLS-1:0] col_drv_en, bl_wr, blb_wr;
`ifdef SRAM_WR_VERIFY_EN
    logic [COLS-1:0] preout;
    logic            verify_err;
    logic            exp_verr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    sram_write_driver_if #(.COLS(COLS)) bus ();

    sram_write_driver #(.COLS(COLS), .PRECH_CYC(2), .DRV_CYC(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (bus.slave),
        .pre_en     (pre_en),
        .wl_en      (wl_en),
        .col_drv_en (col_drv_en),
        .bl_wr      (bl_wr),
        .blb_wr     (blb_wr),
`ifdef SRAM_WR_VERIFY_EN
        .preout     (preout),
        .verify_err (verify_err),
`endif
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_pre"}, 32'(pre_en), 32'd1);
        chk({tag, "_wl"},  32'(wl_en), 32'd0);
        chk({tag, "_drv"}, 32'(col_drv_en), 32'h0);
        chk({tag, "_bl"},  32'(bl_wr), 32'hFFFF);
        chk({tag, "_blb"}, 32'(blb_wr), 32'hFFFF);
    endtask

    // Accepts one word at the next edge, then checks every cycle until ready
    // returns. ebl/eblb/edrv are the hand-computed DRIVE-phase values.
    task automatic do_write(input string tag, input logic [15:0] d, input logic [15:0] m,
                            input logic [15:0] ebl, input logic [15:0] eblb,
                            input logic [15:0] edrv);
        int  last;
        bit  in_drv;
        bit  is_done;
        bus.req_valid = 1'b1;
        bus.wr_data   = d;
        bus.wr_mask   = m;
        chk({tag, "_ready0"}, 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 1'b0;
        bus.wr_data   = 16'h1234;
        bus.wr_mask   = 16'hFFFF;
        last = (m != 0) ? 6 : 1;
        for (int c = 1; c <= last; c++) begin
            in_drv  = (m != 0) && (c >= 3) && (c <= 5);
            is_done = (c == last);
            chk($sformatf("%s_c%0d_wl", tag, c),   32'(wl_en),  32'(in_drv));
            chk($sformatf("%s_c%0d_pre", tag, c),  32'(pre_en), 32'(!in_drv));
            chk($sformatf("%s_c%0d_done", tag, c), 32'(done),   32'(is_done));
            chk($sformatf("%s_c%0d_rdy", tag, c),  32'(bus.req_ready), 32'd0);
            chk($sformatf("%s_c%0d_drv", tag, c),  32'(col_drv_en), in_drv ? 32'(edrv) : 32'h0);
            chk($sformatf("%s_c%0d_bl", tag, c),   32'(bl_wr),  in_drv ? 32'(ebl)  : 32'hFFFF);
            chk($sformatf("%s_c%0d_blb", tag, c),  32'(blb_wr), in_drv ? 32'(eblb) : 32'hFFFF);
`ifdef SRAM_WR_VERIFY_EN
            chk($sformatf("%s_c%0d_verr", tag, c), 32'(verify_err), is_done ? 32'(exp_verr) : 32'd0);
`endif
            step();
        end
        chk({tag, "_ready_end"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_done_end"},  32'(done), 32'd0);
    endtask

    int k;

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.wr_data   = '0;
        bus.wr_mask   = '0;
`ifdef SRAM_WR_VERIFY_EN
        preout   = '0;
        exp_verr = 1'b0;
`endif
        #2;
        chk_idle_outputs("rst");
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        step();
        rst = 1'b0;
        step();

        // Full-mask write
        do_write("single", 16'hA5C3, 16'hFFFF, 16'hA5C3, 16'h5A3C, 16'hFFFF);
        // Partial mask: unmasked columns parked at 1
        do_write("partial", 16'h00FF, 16'h0F0F, 16'hF0FF, 16'hFFF0, 16'h0F0F);
        // Zero mask: straight to RECOVER
        do_write("zero", 16'hABCD, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000);

        // Back-to-back with valid held high; data changes while busy must not
        // be latched until the next accept.
        bus.req_valid = 1'b1;
        bus.wr_data   = 16'h1111;
        bus.wr_mask   = 16'hFFFF;
        step();
        bus.wr_data   = 16'h2222;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            if (wl_en) chk("b2b_first_bl", 32'(bl_wr), 32'h1111);
            step();
            k++;
        end
        // One write per PRECH_CYC+DRV_CYC+2 = 7 clocks
        chk("b2b_accept_gap", 32'(k + 1), 32'd7);
        step();
        bus.req_valid = 1'b0;
        chk("b2b_second_rdy", 32'(bus.req_ready), 32'd0);
        step();
        step();
        chk("b2b_second_wl", 32'(wl_en), 32'd1);
        chk("b2b_second_bl", 32'(bl_wr), 32'h2222);
        for (int i = 0; i < 5; i++) step();
        chk("b2b_idle", 32'(bus.req_ready), 32'd1);

        // Reset in the middle of DRIVE
        bus.req_valid = 1'b1;
        bus.wr_data   = 16'hC3C3;
        bus.wr_mask   = 16'hFFFF;
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        chk("mid_wl_before", 32'(wl_en), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle_outputs("mid_rst");
        chk("mid_rst_done", 32'(done), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("mid_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("mid_nodone%0d", i), 32'(done), 32'd0);
            step();
        end

`ifdef SRAM_WR_VERIFY_EN
        preout   = 16'hA5C2;
        exp_verr = 1'b1;
        do_write("verify_bad", 16'hA5C3, 16'hFFFF, 16'hA5C3, 16'h5A3C, 16'hFFFF);
        exp_verr = 1'b0;
        do_write("verify_ok", 16'hA5C3, 16'hFFFE, 16'hA5C3, 16'h5A3D, 16'hFFFE);
        do_write("verify_zero", 16'hA5C3, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Structural invariants checked on every sample point.
    always @(negedge clk) begin
        if (pre_en && wl_en)
            chk("inv_pre_wl", 32'(pre_en && wl_en), 32'd0);
        if ((~bl_wr & ~blb_wr) != '0)
            chk("inv_bl_blb", 32'(~bl_wr & ~blb_wr), 32'h0);
    end

endmodule
